// File: rtl/led_pattern_sched.sv
// Purpose: three-key LED pattern sequencer (mode / speed / pause) for a 4-LED board.
// Latency: key low -> press pulse 2 + DEBOUNCE_CYC-1 edges; press -> mode/fast/paused 1 edge; step -> led 1 edge.
// Backpressure: none; the keys are level inputs and the outputs are free-running.
//
// Ports:
//   sys_clk    system clock, every flop on the rising edge
//   sys_rst    synchronous active-high reset
//   key_mode   raw push-button, active-low, asynchronous; advances the pattern mode
//   key_speed  raw push-button, active-low, asynchronous; toggles slow/fast stepping
//   key_pause  raw push-button, active-low, asynchronous; freezes/unfreezes stepping
//   led        registered LED drive, 1 = on
//   mode       current mode: 0 CHASE, 1 BLINK, 2 BOUNCE, 3 BINARY
//   fast       1 = fast step period selected
//   paused     1 = stepping frozen
//   tick_out   one-cycle pulse on every accepted step
module led_pattern_sched #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned TICK_SLOW    = 25000000,
  parameter int unsigned TICK_FAST    = 6250000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_mode,
  input  logic       key_speed,
  input  logic       key_pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       fast,
  output logic       paused,
  output logic       tick_out
);

  // ---------------------------------------------------------------------------
  // Sizing. DEBOUNCE_CYC is assumed >= 2 so that the arm value DEBOUNCE_CYC-2
  // exists; both tick periods are assumed >= 2 so that a freshly cleared
  // counter never sits on its terminal value.
  // ---------------------------------------------------------------------------
  localparam int NKEY      = 3;
  localparam int KEY_MODE  = 0;
  localparam int KEY_SPEED = 1;
  localparam int KEY_PAUSE = 2;

  localparam int unsigned DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  // Terminal values are computed in 32 bits and only then narrowed, so the
  // compares below never see a truncated parameter.
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0] DB_ARM    = DB_W'(DEBOUNCE_CYC - 2);
  localparam logic [TW-1:0]   SLOW_LAST = TW'(TICK_SLOW - 1);
  localparam logic [TW-1:0]   FAST_LAST = TW'(TICK_FAST - 1);

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BINARY = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // Key synchronisers and debouncers
  // ---------------------------------------------------------------------------
  logic [NKEY-1:0] keys_raw;
  logic [NKEY-1:0] sync1_q;
  logic [NKEY-1:0] sync2_q;
  logic [DB_W-1:0] db_cnt_q [NKEY];
  logic [DB_W-1:0] db_cnt_d [NKEY];
  logic [NKEY-1:0] press_q;
  logic [NKEY-1:0] press_d;

  assign keys_raw = {key_pause, key_speed, key_mode};

  // The counter saturates at DB_LAST, so the DB_ARM -> DB_LAST step happens
  // once per hold: that single transition is the press. Any released sample
  // restarts the count, which is what rejects bounce.
  always_comb begin
    for (int k = 0; k < NKEY; k++) begin
      db_cnt_d[k] = db_cnt_q[k];
      press_d[k]  = 1'b0;
      if (sync2_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] != DB_LAST) begin
        db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        press_d[k]  = (db_cnt_q[k] == DB_ARM);
      end
    end
  end

  // Sync stages reset to the released level so a reset never manufactures
  // a press edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      press_q <= '0;
      for (int k = 0; k < NKEY; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      press_q <= press_d;
      for (int k = 0; k < NKEY; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  logic mode_press;
  logic speed_press;
  logic pause_press;

  assign mode_press  = press_q[KEY_MODE];
  assign speed_press = press_q[KEY_SPEED];
  assign pause_press = press_q[KEY_PAUSE];

  // ---------------------------------------------------------------------------
  // Step tick generator, speed and pause flags
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;
  logic [TW-1:0] tick_last;
  logic          at_last;
  logic          tick;
  logic          fast_q;
  logic          fast_d;
  logic          paused_q;
  logic          paused_d;

  // A speed press restarts the period from zero and swallows a tick that
  // would otherwise land in the same cycle, so the first step after a speed
  // change is always a full new period away.
  always_comb begin
    tick_last = fast_q ? FAST_LAST : SLOW_LAST;
    at_last   = (tcnt_q == tick_last);
    tick      = at_last && !paused_q && !speed_press;

    tcnt_d = tcnt_q;
    if (speed_press) begin
      tcnt_d = '0;
    end else if (!paused_q) begin
      tcnt_d = at_last ? '0 : tcnt_q + 1'b1;
    end

    fast_d   = fast_q ^ speed_press;
    paused_d = paused_q ^ pause_press;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tcnt_q   <= '0;
      fast_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      fast_q   <= fast_d;
      paused_q <= paused_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode state machine and step register
  // ---------------------------------------------------------------------------
  mode_e       mode_q;
  mode_e       mode_d;
  logic [3:0]  step_q;
  logic [3:0]  step_d;
  logic [3:0]  step_last;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q <= MODE_CHASE;
      step_q <= '0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  // A mode press outranks a coincident tick: the new mode always starts
  // from its first pattern entry.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;

    unique case (mode_q)
      MODE_CHASE:  step_last = 4'd3;
      MODE_BLINK:  step_last = 4'd1;
      MODE_BOUNCE: step_last = 4'd5;
      MODE_BINARY: step_last = 4'd15;
      default:     step_last = 4'd3;
    endcase

    if (mode_press) begin
      unique case (mode_q)
        MODE_CHASE:  mode_d = MODE_BLINK;
        MODE_BLINK:  mode_d = MODE_BOUNCE;
        MODE_BOUNCE: mode_d = MODE_BINARY;
        MODE_BINARY: mode_d = MODE_CHASE;
        default:     mode_d = MODE_CHASE;
      endcase
      step_d = '0;
    end else if (tick) begin
      step_d = (step_q == step_last) ? 4'd0 : step_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern decode and LED register
  // ---------------------------------------------------------------------------
  logic [3:0] pattern;
  logic [3:0] led_q;

  always_comb begin
    pattern = 4'b0000;
    unique case (mode_q)
      MODE_CHASE:  pattern = 4'b0001 << step_q[1:0];
      MODE_BLINK:  pattern = {4{step_q[0]}};
      MODE_BOUNCE: begin
        // Walk out to LED3 and back without repeating the end LEDs.
        unique case (step_q)
          4'd0:    pattern = 4'b0001;
          4'd1:    pattern = 4'b0010;
          4'd2:    pattern = 4'b0100;
          4'd3:    pattern = 4'b1000;
          4'd4:    pattern = 4'b0100;
          4'd5:    pattern = 4'b0010;
          default: pattern = 4'b0001;
        endcase
      end
      MODE_BINARY: pattern = step_q;
      default:     pattern = 4'b0000;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_q <= 4'b0000;
    end else begin
      led_q <= pattern;
    end
  end

  assign led      = led_q;
  assign mode     = mode_q;
  assign fast     = fast_q;
  assign paused   = paused_q;
  assign tick_out = tick;

endmodule

// File: tb/tb_led_pattern_sched.sv
module tb_led_pattern_sched;

  localparam int unsigned DB = 4;
  localparam int unsigned TS = 8;
  localparam int unsigned TF = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_mode;
  logic       key_speed;
  logic       key_pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       fast;
  logic       paused;
  logic       tick_out;

  led_pattern_sched #(
    .DEBOUNCE_CYC(DB),
    .TICK_SLOW   (TS),
    .TICK_FAST   (TF)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_mode (key_mode),
    .key_speed(key_speed),
    .key_pause(key_pause),
    .led      (led),
    .mode     (mode),
    .fast     (fast),
    .paused   (paused),
    .tick_out (tick_out)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_chk;
  int         n_pass;
  bit         sb_on;
  bit         pend1;
  bit         pend2;
  logic [3:0] exp_q [$];
  logic [3:0] exp_led;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: advance to the falling edge, then score the LED two cycles
  // after every observed tick against the next queued expectation.
  task automatic tick_clk();
    @(negedge sys_clk);
    if (sb_on) begin
      if (pend2) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", exp_q.size(), 1);
        end else begin
          exp_led = exp_q.pop_front();
          chk("sb_led", 32'(led), 32'(exp_led));
        end
      end
      pend2 = pend1;
      pend1 = tick_out;
    end else begin
      pend1 = 1'b0;
      pend2 = 1'b0;
    end
  endtask

  task automatic sb_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick_clk();
      n++;
    end
    chk("sb_drain", exp_q.size(), 0);
    exp_q.delete();
    sb_on = 1'b0;
    pend1 = 1'b0;
    pend2 = 1'b0;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (tick_out !== 1'b1 && n < budget);
    if (tick_out !== 1'b1) chk("tick_timeout", 32'(tick_out), 1);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_mode  = v;
      1:       key_speed = v;
      default: key_pause = v;
    endcase
  endtask

  task automatic press(input int k, input int hold);
    set_key(k, 1'b0);
    repeat (hold) tick_clk();
    set_key(k, 1'b1);
  endtask

  task automatic push4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad_led;
    int n_ticks;
    n_chk   = 0;
    n_pass  = 0;
    sb_on   = 1'b0;
    pend1   = 1'b0;
    pend2   = 1'b0;
    sys_rst = 1'b1;
    key_mode  = 1'b1;
    key_speed = 1'b1;
    key_pause = 1'b1;

    // Reset values
    repeat (3) tick_clk();
    chk("rst_led",    32'(led),      0);
    chk("rst_mode",   32'(mode),     0);
    chk("rst_fast",   32'(fast),     0);
    chk("rst_paused", 32'(paused),   0);
    chk("rst_tick",   32'(tick_out), 0);

    // Idle CHASE at slow speed
    sys_rst = 1'b0;
    sb_on = 1'b1;
    push4(4'b0010, 4'b0100, 4'b1000, 4'b0001);
    tick_clk();
    chk("led_after_rst", 32'(led), 1);
    wait_tick(20, n);
    chk("first_tick", n, 6);
    repeat (3) begin
      wait_tick(20, n);
      chk("slow_gap", n, 8);
    end
    sb_drain(10);

    // Long mode hold: one step to BLINK
    wait_tick(20, n);
    key_mode = 1'b0;
    repeat (5) tick_clk();
    chk("mode_pre_lat", 32'(mode), 0);
    tick_clk();
    chk("mode_to_blink", 32'(mode), 1);
    sb_on = 1'b1;
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1111);
    tick_clk();
    chk("blink_step0", 32'(led), 0);
    repeat (13) tick_clk();
    key_mode = 1'b1;
    sb_drain(40);
    chk("mode_one_pulse", 32'(mode), 1);

    // Re-press: BOUNCE full cycle
    wait_tick(20, n);
    press(0, 6);
    chk("mode_to_bounce", 32'(mode), 2);
    sb_on = 1'b1;
    push4(4'b0010, 4'b0100, 4'b1000, 4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    tick_clk();
    chk("bounce_step0", 32'(led), 1);
    sb_drain(80);

    // Bounce rejection
    key_mode = 1'b0; repeat (2) tick_clk();
    key_mode = 1'b1; repeat (1) tick_clk();
    key_mode = 1'b0; repeat (2) tick_clk();
    key_mode = 1'b1; repeat (10) tick_clk();
    chk("glitch_no_change", 32'(mode), 2);

    // Clean 10-cycle hold into BINARY, then count up to step 5
    wait_tick(20, n);
    key_mode = 1'b0;
    repeat (6) tick_clk();
    chk("mode_to_binary", 32'(mode), 3);
    sb_on = 1'b1;
    push4(4'b0001, 4'b0010, 4'b0011, 4'b0100);
    exp_q.push_back(4'b0101);
    tick_clk();
    chk("binary_step0", 32'(led), 0);
    repeat (3) tick_clk();
    key_mode = 1'b1;
    sb_drain(60);
    chk("binary_one_pulse", 32'(mode), 3);

    // Pause at step 5: the pending tick is blocked and everything freezes
    press(2, 6);
    chk("paused_on", 32'(paused), 1);
    chk("pause_tick_blocked", 32'(tick_out), 0);
    bad_led = 0;
    n_ticks = 0;
    repeat (50) begin
      tick_clk();
      if (led !== 4'b0101) bad_led++;
      if (tick_out !== 1'b0) n_ticks++;
    end
    chk("pause_led_frozen", bad_led, 0);
    chk("pause_no_tick", n_ticks, 0);

    // Mode press while paused
    press(0, 6);
    chk("paused_mode_wrap", 32'(mode), 0);
    chk("paused_still", 32'(paused), 1);
    tick_clk();
    chk("paused_chase_led", 32'(led), 1);

    // Resume: stepping continues from step 0 of CHASE
    sb_on = 1'b1;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    press(2, 6);
    chk("paused_off", 32'(paused), 0);
    chk("resume_led", 32'(led), 1);
    sb_drain(20);

    // Speed press landing on the terminal count: tick swallowed, period restarts
    wait_tick(20, n);
    repeat (3) tick_clk();
    key_speed = 1'b0;
    repeat (5) tick_clk();
    chk("spd_tick_suppress", 32'(tick_out), 0);
    chk("spd_fast_pre", 32'(fast), 0);
    tick_clk();
    chk("spd_fast_on", 32'(fast), 1);
    key_speed = 1'b1;
    wait_tick(20, n);
    chk("fast_first_tick", n, 1);
    repeat (2) begin
      wait_tick(20, n);
      chk("fast_gap", n, 2);
    end
    press(1, 6);
    chk("spd_fast_off", 32'(fast), 0);
    wait_tick(20, n);
    chk("slow_first_tick", n, 7);
    wait_tick(20, n);
    chk("slow_gap_again", n, 8);

    // All three keys in the same cycle
    key_mode  = 1'b0;
    key_speed = 1'b0;
    key_pause = 1'b0;
    repeat (6) tick_clk();
    key_mode  = 1'b1;
    key_speed = 1'b1;
    key_pause = 1'b1;
    chk("multi_mode",   32'(mode),   1);
    chk("multi_fast",   32'(fast),   1);
    chk("multi_paused", 32'(paused), 1);
    repeat (3) tick_clk();
    press(0, 6);
    repeat (3) tick_clk();
    press(0, 6);
    repeat (3) tick_clk();
    chk("pre_rst_mode", 32'(mode), 3);

    // Reset with the speed key one cycle short of its press
    key_speed = 1'b0;
    repeat (4) tick_clk();
    chk("pre_rst_fast",   32'(fast),   1);
    chk("pre_rst_paused", 32'(paused), 1);
    sys_rst   = 1'b1;
    key_speed = 1'b1;
    tick_clk();
    chk("rst2_led",    32'(led),      0);
    chk("rst2_mode",   32'(mode),     0);
    chk("rst2_fast",   32'(fast),     0);
    chk("rst2_paused", 32'(paused),   0);
    chk("rst2_tick",   32'(tick_out), 0);
    sys_rst = 1'b0;
    repeat (6) tick_clk();
    chk("no_ghost_press", 32'(fast), 0);
    chk("rst2_led_run",   32'(led),  1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
